muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit with its own HI/LO register pair and funct decoder. It sits beside the single-cycle ALU in the execute stage and handles MIPS mult/multu/div/divu/mthi/mtlo/mfhi/mflo. Multiply and divide are iterative, one bit per cycle. Control uses a start/busy/done handshake so the core can stall on busy.

Parameters:
WIDTH, 32, operand and HI/LO width (>= 4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
funct  input  6  MIPS R-type funct field, sampled with start
a  input  WIDTH  rs operand (multiplicand/dividend, mthi/mtlo data)
b  input  WIDTH  rt operand (multiplier/divisor)
flush  input  1  abort current operation (pipeline exception)
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO just updated by mult/div
div0  output  1  valid with done: divisor was zero
illegal  output  1  one-cycle pulse: start with unsupported funct
rdata  output  WIDTH  combinational: HI if funct=010000, LO if funct=010010, else 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE; hi=lo=0; busy=done=div0=illegal=0; counter and datapath registers 0. Reset mid-operation abandons it immediately.
- Decode at start, IDLE only:
  - 011000 mult (signed), 011001 multu, 011010 div (signed), 011011 divu: load operands and go to CALC.
  - 010001 mthi: hi<=a at that edge, no busy.
  - 010011 mtlo: lo<=a at that edge, no busy.
  - 010000 mfhi, 010010 mflo: no state change; data is read via rdata.
  - Any other funct: illegal=1 for one cycle, no state change.
- start while busy=1 is ignored entirely, including mthi/mtlo; the core must stall.
- States and transitions:
  - IDLE -> CALC on mult/div start.
  - CALC runs exactly WIDTH cycles, then -> FIX.
  - FIX takes 1 cycle, then -> IDLE.
- Signed operations:
  - Operands are converted to magnitudes at the start edge; sign flags are latched.
  - Product sign is sa^sb. Quotient sign is sa^sb. Remainder sign is sa.
- Multiply: shift-add on a 2*WIDTH accumulator, one multiplier bit per CALC cycle.
- Divide: restoring division, one quotient bit per CALC cycle.
- FIX cycle:
  - Apply sign correction (two's-complement negate) and write the results.
  - mult: {hi,lo} <= product.
  - div: lo <= quotient, hi <= remainder.
- Timing:
  - Start sampled at edge E0; busy=1 from E0 through the FIX cycle.
  - HI/LO are written at edge E(WIDTH+1).
  - In the cycle after E(WIDTH+1): done=1, busy=0, new hi/lo visible.
  - Total latency is WIDTH+1 cycles; a new start is accepted in that same done cycle.
- Divide by zero: no trap. Result is lo=all-ones, hi=a (original signed value), div0=1 with done. Still takes the full WIDTH+1 cycles.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0, div0=0. This falls out of the magnitude algorithm and needs no special case.
- flush:
  - In CALC or FIX: return to IDLE at that edge; hi/lo unchanged; no done.
  - flush has priority over start in the same cycle.
  - flush in IDLE has no effect.
- done, div0 and illegal are registered single-cycle pulses. div0 is 0 whenever done=0.

Test Plan:
- WIDTH=32, mult a=FFFFFFFD (-3), b=00000007 -> done exactly 33 cycles after start; hi=FFFFFFFF, lo=FFFFFFEB; busy high for 33 cycles.
- multu a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; then mult with the same operands -> hi=00000000, lo=00000001.
- div a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. divu a=7, b=0 -> lo=FFFFFFFF, hi=00000007, div0=1. div a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div0=0.
- mthi a=12345678, next cycle mtlo a=9ABCDEF0 -> hi/lo updated one edge later, busy never set. mfhi -> rdata=12345678; funct=100000 -> illegal pulse, hi/lo unchanged.
- Start divu, assert flush at cycle 10 -> busy=0 next cycle, no done, hi/lo hold old values. Start mult during busy -> ignored; result matches the first operation.
- Drop rst_n mid-CALC asynchronously (between edges) -> busy/hi/lo go to 0 immediately. Back-to-back mult started in the done cycle -> accepted, second done 33 cycles later.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with its own HI/LO pair.
// Handles MIPS mult/multu/div/divu (one bit per cycle) and mthi/mtlo/mfhi/mflo.
// Signed operations work on magnitudes. The sign correction is applied in a single FIX cycle.
//
// Handshake: start is sampled only while busy=0. busy stays high from the
// start edge through the FIX cycle. done is a one-cycle pulse that appears
// together with the new HI/LO values, and a new start is accepted in that
// same done cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic             illegal,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;    // mult: upper product half; div: partial remainder
  logic [WIDTH-1:0] acc_lo;    // mult: multiplier/lower product; div: dividend/quotient
  logic [WIDTH-1:0] opnd;      // mult: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0] a_orig;    // original rs value, returned in HI on divide by zero
  logic             is_div;
  logic             neg_q;     // negate product / quotient
  logic             neg_r;     // negate remainder
  logic             zero_div;

  logic             op_mul, op_div, op_signed, op_md, op_known;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Decode, operand magnitudes, one iteration step and the sign fix-up
  always_comb begin
    op_mul    = (funct == F_MULT) || (funct == F_MULTU);
    op_div    = (funct == F_DIV)  || (funct == F_DIVU);
    op_signed = (funct == F_MULT) || (funct == F_DIV);
    op_md     = op_mul || op_div;
    op_known  = op_md || (funct == F_MTHI) || (funct == F_MTLO) ||
                (funct == F_MFHI) || (funct == F_MFLO);
    a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
    // Shift-add: add the multiplicand when the current multiplier bit is set
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    // Restoring divide: the MSB of the trial result set means "restore"
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_q ? -prod : prod;
    quot_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix   = neg_r ? -acc_hi : acc_hi;
  end

  // Read port for mfhi/mflo
  always_comb begin
    rdata = '0;
    if (funct == F_MFHI) rdata = hi;
    else if (funct == F_MFLO) rdata = lo;
  end

  assign busy = (state != IDLE);

  // Control FSM plus datapath. done, div0 and illegal are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div0     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done    <= 1'b0;
      div0    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_md) begin
              state    <= CALC;
              cnt      <= '0;
              acc_hi   <= '0;
              acc_lo   <= op_div ? a_mag : b_mag;
              opnd     <= op_div ? b_mag : a_mag;
              a_orig   <= a;
              is_div   <= op_div;
              neg_q    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r    <= op_signed && a[WIDTH-1];
              zero_div <= op_div && (b == '0);
            end else if (funct == F_MTHI) begin
              hi <= a;
            end else if (funct == F_MTLO) begin
              lo <= a;
            end else if (!op_known) begin
              illegal <= 1'b1;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              acc_hi <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (zero_div) begin
              lo   <= '1;
              hi   <= a_orig;
              div0 <= 1'b1;
            end else begin
              lo <= quot_fix;
              hi <= rem_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
